shape_plot_engine: RTL and testbench

- Parametrised pixel-drawing engine between user controls (switches/keys) and the vga_adapter plot interface.
- Draws one shape per start/done transaction, one pixel per cycle.
- Modes: full-screen clear, midpoint circle outline, filled square.
- Generalises the fixed-160x120, single-shape drawer: configurable screen size and coordinate widths, mode select, off-screen clipping, busy flag.

---
 rtl/shape_plot_if.sv | 35 +++
 rtl/shape_plot_engine.sv | 131 +++++++++++++
 tb/tb_shape_plot_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shape_plot_if.sv
// shape_plot_if: control and plot bundle between user controls and shape_plot_engine (SHAPE_PLOT_COUNT_EN adds plot_count)
interface shape_plot_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           start;
    logic [1:0]     mode;
    logic [2:0]     colour;
    logic [X_W-1:0] centre_x;
    logic [Y_W-1:0] centre_y;
    logic [X_W-1:0] diameter;
    logic           busy;
    logic           done;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot;
`ifdef SHAPE_PLOT_COUNT_EN
    logic [15:0]    plot_count;
`endif
    modport master (
        output start, mode, colour, centre_x, centre_y, diameter,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
`ifdef SHAPE_PLOT_COUNT_EN
        , input plot_count
`endif
    );
    modport slave (
        input  start, mode, colour, centre_x, centre_y, diameter,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
`ifdef SHAPE_PLOT_COUNT_EN
        , output plot_count
`endif
    );
endinterface

// File: rtl/shape_plot_engine.sv
// shape_plot_engine: clear / midpoint circle / filled square plotter, one candidate pixel per cycle, clipped to the screen (SHAPE_PLOT_COUNT_EN adds plot_count)
module shape_plot_engine #(
    parameter int SCR_W = 160,
    parameter int SCR_H = 120,
    parameter int X_W   = 8,
    parameter int Y_W   = 7
) (
    input logic         CLOCK_50,
    input logic         rst_n,
    shape_plot_if.slave bus
);
    localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam logic signed [W-1:0] SW  = W'(SCR_W);
    localparam logic signed [W-1:0] SH  = W'(SCR_H);
    localparam logic signed [W-1:0] ONE = W'(1);
    localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, CIRC = 3'd2, SQR = 3'd3, DONE = 3'd4;

    logic [2:0]          state_q, state_d, oct_q, oct_d, col_q, col_d;
    logic signed [W-1:0] a_q, a_d, b_q, b_d, crit_q, crit_d;
    logic signed [W-1:0] cx_q, cx_d, cy_q, cy_d, r_q, r_d;
    logic signed [W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic                cand_v_q, cand_v_d;
    logic [X_W-1:0]      vga_x_q, vga_x_d;
    logic [Y_W-1:0]      vga_y_q, vga_y_d;
    logic [2:0]          vga_colour_q, vga_colour_d;
    logic                vga_plot_q, vga_plot_d, busy_q, busy_d, done_q, done_d;
    logic signed [W-1:0] r_in, oy_n, ox_n, u, v, crit_nxt;
    logic                crit_le0, on_scr;
`ifdef SHAPE_PLOT_COUNT_EN
    logic [15:0]         cnt_q, cnt_d;
`endif

    // a_q/b_q hold x,y for clear, dx,dy offsets for square, ox,oy for circle
    always_comb begin
        state_d = state_q; a_d = a_q; b_d = b_q; crit_d = crit_q; oct_d = oct_q;
        cx_d = cx_q; cy_d = cy_q; r_d = r_q; col_d = col_q;
        cand_v_d = 1'b0; cand_x_d = cand_x_q; cand_y_d = cand_y_q;
        r_in = W'(bus.diameter >> 1);
        u = oct_q[0] ? b_q : a_q;
        v = oct_q[0] ? a_q : b_q;
        crit_le0 = crit_q[W-1] | ~|crit_q;
        oy_n = b_q + ONE;
        ox_n = crit_le0 ? a_q : a_q - ONE;
        crit_nxt = crit_q + ONE + (crit_le0 ? (oy_n <<< 1) : ((oy_n - ox_n) <<< 1));
        case (state_q)
            IDLE: if (bus.start) begin
                col_d = bus.colour;
                cx_d = W'(bus.centre_x);
                cy_d = W'(bus.centre_y);
                r_d = r_in;
                b_d = '0;
                a_d = '0;
                oct_d = '0;
                crit_d = ONE - r_in;
                case (bus.mode)
                    2'b00: state_d = CLEAR;
                    2'b01: begin state_d = CIRC; a_d = r_in; end
                    2'b10: begin state_d = SQR; a_d = -r_in; b_d = -r_in; end
                    default: state_d = DONE;
                endcase
            end
            CLEAR: begin
                cand_v_d = 1'b1; cand_x_d = a_q; cand_y_d = b_q;
                b_d = (b_q == SH - ONE) ? '0 : b_q + ONE;
                a_d = (b_q == SH - ONE) ? a_q + ONE : a_q;
                state_d = (b_q == SH - ONE && a_q == SW - ONE) ? DONE : CLEAR;
            end
            SQR: begin
                cand_v_d = 1'b1; cand_x_d = cx_q + a_q; cand_y_d = cy_q + b_q;
                b_d = (b_q == r_q) ? -r_q : b_q + ONE;
                a_d = (b_q == r_q) ? a_q + ONE : a_q;
                state_d = (b_q == r_q && a_q == r_q) ? DONE : SQR;
            end
            CIRC: begin
                cand_v_d = 1'b1;
                cand_x_d = cx_q + ((oct_q[2] ^ oct_q[1]) ? -u : u);
                cand_y_d = cy_q + (oct_q[2] ? -v : v);
                oct_d = oct_q + 3'd1;
                if (oct_q == 3'd7) begin
                    b_d = oy_n; a_d = ox_n; crit_d = crit_nxt;
                    state_d = (oy_n > ox_n) ? DONE : CIRC;
                end
            end
            DONE: state_d = (done_q && !bus.start) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        on_scr = cand_v_q && !cand_x_q[W-1] && (cand_x_q < SW) && !cand_y_q[W-1] && (cand_y_q < SH);
        vga_plot_d = on_scr;
        vga_x_d = on_scr ? cand_x_q[X_W-1:0] : vga_x_q;
        vga_y_d = on_scr ? cand_y_q[Y_W-1:0] : vga_y_q;
        vga_colour_d = on_scr ? col_q : vga_colour_q;
        done_d = (state_q == DONE) && !cand_v_q && !(done_q && !bus.start);
        busy_d = (state_d != IDLE) && !done_d;
`ifdef SHAPE_PLOT_COUNT_EN
        cnt_d = (state_q == IDLE && bus.start) ? 16'd0 : cnt_q + 16'(vga_plot_d);
`endif
    end

    // all state and outputs registered; synchronous active-low reset aborts any shape
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q <= IDLE; a_q <= '0; b_q <= '0; crit_q <= '0; oct_q <= '0;
            cx_q <= '0; cy_q <= '0; r_q <= '0; col_q <= '0;
            cand_v_q <= 1'b0; cand_x_q <= '0; cand_y_q <= '0;
            vga_x_q <= '0; vga_y_q <= '0; vga_colour_q <= '0; vga_plot_q <= 1'b0;
            busy_q <= 1'b0; done_q <= 1'b0;
`ifdef SHAPE_PLOT_COUNT_EN
            cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d; a_q <= a_d; b_q <= b_d; crit_q <= crit_d; oct_q <= oct_d;
            cx_q <= cx_d; cy_q <= cy_d; r_q <= r_d; col_q <= col_d;
            cand_v_q <= cand_v_d; cand_x_q <= cand_x_d; cand_y_q <= cand_y_d;
            vga_x_q <= vga_x_d; vga_y_q <= vga_y_d; vga_colour_q <= vga_colour_d; vga_plot_q <= vga_plot_d;
            busy_q <= busy_d; done_q <= done_d;
`ifdef SHAPE_PLOT_COUNT_EN
            cnt_q <= cnt_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.vga_x = vga_x_q;
    assign bus.vga_y = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot = vga_plot_q;
`ifdef SHAPE_PLOT_COUNT_EN
    assign bus.plot_count = cnt_q;
`endif
endmodule

// File: tb/tb_shape_plot_engine.sv
// tb_shape_plot_engine: directed self-checking bench for shape_plot_engine
module tb_shape_plot_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0, t_done, n_keep;
    int px[$], py[$], pc[$], pt[$];

    shape_plot_if #(.X_W(8), .Y_W(7)) bus();
    shape_plot_engine #(.SCR_W(160), .SCR_H(120), .X_W(8), .Y_W(7)) dut (
        .CLOCK_50(clk), .rst_n(rst_n), .bus(bus)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (bus.vga_plot === 1'b1) begin
            px.push_back(int'(bus.vga_x));
            py.push_back(int'(bus.vga_y));
            pc.push_back(int'(bus.vga_colour));
            pt.push_back(cyc);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int circ_iters(input int r);
        int ox = r, oy = 0, crit = 1 - r, n = 0;
        while (oy <= ox) begin
            n++;
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin ox--; crit += 2 * (oy - ox) + 1; end
        end
        return n;
    endfunction

    function automatic int has_pt(input int x, input int y);
        foreach (px[i]) if (px[i] == x && py[i] == y) return 1;
        return 0;
    endfunction

    function automatic int n_outside(input int xl, input int xh, input int yl, input int yh);
        int n = 0;
        foreach (px[i]) if (px[i] < xl || px[i] > xh || py[i] < yl || py[i] > yh) n++;
        return n;
    endfunction

    function automatic int n_off_radius(input int cx, input int cy, input int r);
        int n = 0, d2;
        foreach (px[i]) begin
            d2 = (px[i] - cx) * (px[i] - cx) + (py[i] - cy) * (py[i] - cy);
            if (d2 < (r - 1) * (r - 1) || d2 > (r + 1) * (r + 1)) n++;
        end
        return n;
    endfunction

    function automatic int n_colour_not(input int c);
        int n = 0;
        foreach (pc[i]) if (pc[i] != c) n++;
        return n;
    endfunction

    task automatic go(input logic [1:0] m, input logic [2:0] c, input int x, input int y, input int d, input int budget);
        int k = 0;
        px.delete(); py.delete(); pc.delete(); pt.delete();
        bus.mode = m; bus.colour = c;
        bus.centre_x = 8'(x); bus.centre_y = 7'(y); bus.diameter = 8'(d);
        bus.start = 1'b1;
        t0 = cyc;
        step();
        bus.mode = ~m; bus.colour = ~c;
        bus.centre_x = 8'(x + 7); bus.centre_y = 7'(y + 3); bus.diameter = 8'(d + 6);
        while (bus.done !== 1'b1 && k < budget) begin step(); k++; end
        t_done = cyc;
        ck("done_within_budget", {31'd0, bus.done}, 32'd1);
`ifdef SHAPE_PLOT_COUNT_EN
        ck("plot_count", 32'(bus.plot_count), 32'(px.size()));
`endif
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        step();
        step();
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 2'b00; bus.colour = 3'b000;
        bus.centre_x = '0; bus.centre_y = '0; bus.diameter = '0;
        repeat (3) step();
        ck("rst_busy", {31'd0, bus.busy}, 32'd0);
        ck("rst_done", {31'd0, bus.done}, 32'd0);
        ck("rst_plot", {31'd0, bus.vga_plot}, 32'd0);
        ck("rst_x", 32'(bus.vga_x), 32'd0);
        ck("rst_y", 32'(bus.vga_y), 32'd0);
        ck("rst_colour", 32'(bus.vga_colour), 32'd0);
        rst_n = 1'b1;
        step();

        go(2'b00, 3'b101, 0, 0, 0, 20000);
        ck("clr_count", 32'(px.size()), 32'd19200);
        ck("clr_first", 32'(px[0] * 1000 + py[0]), 32'd0);
        ck("clr_second", 32'(px[1] * 1000 + py[1]), 32'd1);
        ck("clr_last", 32'(px[px.size()-1] * 1000 + py[py.size()-1]), 32'd159119);
        ck("clr_colour_bad", 32'(n_colour_not(5)), 32'd0);
        ck("clr_first_latency", 32'(pt[0] - t0), 32'd3);
        ck("clr_done_after_last", 32'(t_done - pt[pt.size()-1]), 32'd1);
        ck("clr_total_cycles", 32'(t_done - t0), 32'd19203);
        ck("clr_busy_in_done", {31'd0, bus.busy}, 32'd0);
        release_start();

        go(2'b01, 3'b010, 80, 60, 80, 2000);
        ck("c40_count", 32'(px.size()), 32'(8 * circ_iters(40)));
        ck("c40_first", 32'(px[0] * 1000 + py[0]), 32'd120060);
        ck("c40_second", 32'(px[1] * 1000 + py[1]), 32'd80100);
        ck("c40_pt_120_60", 32'(has_pt(120, 60)), 32'd1);
        ck("c40_pt_40_60", 32'(has_pt(40, 60)), 32'd1);
        ck("c40_pt_80_100", 32'(has_pt(80, 100)), 32'd1);
        ck("c40_pt_80_20", 32'(has_pt(80, 20)), 32'd1);
        ck("c40_radius_bad", 32'(n_off_radius(80, 60, 40)), 32'd0);
        repeat (5) step();
        ck("c40_done_held", {31'd0, bus.done}, 32'd1);
        ck("c40_busy_held", {31'd0, bus.busy}, 32'd0);
        ck("c40_no_retrigger", 32'(px.size()), 32'(8 * circ_iters(40)));
        bus.start = 1'b0;
        step();
        ck("c40_done_drop", {31'd0, bus.done}, 32'd0);
        step();

        go(2'b01, 3'b001, 80, 60, 0, 200);
        ck("c0_count", 32'(px.size()), 32'd8);
        ck("c0_outside", 32'(n_outside(80, 80, 60, 60)), 32'd0);
        release_start();
        go(2'b01, 3'b001, 80, 60, 1, 200);
        ck("c1_count", 32'(px.size()), 32'd8);
        ck("c1_outside", 32'(n_outside(80, 80, 60, 60)), 32'd0);
        release_start();

        go(2'b01, 3'b111, 0, 0, 20, 1000);
        ck("corner_outside", 32'(n_outside(0, 10, 0, 10)), 32'd0);
        ck("corner_pt_10_0", 32'(has_pt(10, 0)), 32'd1);
        ck("corner_pt_0_10", 32'(has_pt(0, 10)), 32'd1);
        ck("corner_total_cycles", 32'(t_done - t0), 32'(8 * circ_iters(10) + 3));
        release_start();

        go(2'b10, 3'b011, 80, 60, 4, 200);
        ck("sq_count", 32'(px.size()), 32'd25);
        ck("sq_outside", 32'(n_outside(78, 82, 58, 62)), 32'd0);
        ck("sq_first", 32'(px[0] * 1000 + py[0]), 32'd78058);
        ck("sq_last", 32'(px[24] * 1000 + py[24]), 32'd82062);
        release_start();

        go(2'b10, 3'b011, 159, 119, 4, 200);
        ck("sqedge_count", 32'(px.size()), 32'd9);
        ck("sqedge_outside", 32'(n_outside(157, 159, 117, 119)), 32'd0);
        ck("sqedge_total_cycles", 32'(t_done - t0), 32'd28);
        release_start();

        go(2'b11, 3'b110, 80, 60, 40, 50);
        ck("rsv_count", 32'(px.size()), 32'd0);
        ck("rsv_total_cycles", 32'(t_done - t0), 32'd2);
        release_start();

        px.delete(); py.delete(); pc.delete(); pt.delete();
        bus.mode = 2'b00; bus.colour = 3'b100; bus.start = 1'b1;
        for (int k = 0; k < 300 && px.size() < 100; k++) step();
        ck("mid_reached_100", 32'(px.size()), 32'd100);
        ck("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0; bus.start = 1'b0;
        step();
        ck("mid_rst_plot", {31'd0, bus.vga_plot}, 32'd0);
        ck("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        ck("mid_rst_done", {31'd0, bus.done}, 32'd0);
`ifdef SHAPE_PLOT_COUNT_EN
        ck("mid_rst_count", 32'(bus.plot_count), 32'd0);
`endif
        n_keep = px.size();
        rst_n = 1'b1;
        repeat (4) step();
        ck("mid_no_more_plots", 32'(px.size()), 32'(n_keep));

        go(2'b01, 3'b010, 80, 60, 80, 2000);
        ck("post_c40_count", 32'(px.size()), 32'(8 * circ_iters(40)));
        ck("post_c40_pt_80_20", 32'(has_pt(80, 20)), 32'd1);
        ck("post_c40_colour_bad", 32'(n_colour_not(2)), 32'd0);
        release_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
